// File: rtl/master_wb_bridge.sv
// master_wb_bridge: turns held CPU load/store requests into single Wishbone B3 classic cycles.
// Optional ack timeout is compiled in by defining MASTER_WB_TIMEOUT_EN.
module master_wb_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        done_o,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_data_out,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [31:0] wbm_dat_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t      r_state, w_state;
  logic        r_done, w_done, r_cyc, w_cyc, r_we, w_we;
  logic [3:0]  r_sel, w_sel;
  logic [31:0] r_adr, w_adr, r_dat, w_dat, r_rdata, w_rdata;
  logic        w_to;
`ifdef MASTER_WB_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (r_state == BUS) ? r_cnt + 16'd1 : '0;
  assign w_to = (r_cnt + 16'd1 == 16'(TIMEOUT_CYCLES));
`else
  // The legal range starts at 1, so this never fires; BUS waits for ack forever.
  assign w_to = (TIMEOUT_CYCLES == 0);
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_done  <= w_done;
      r_cyc   <= w_cyc;
      r_we    <= w_we;
      r_sel   <= w_sel;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_rdata <= w_rdata;
    end
  always_comb begin
    w_state = r_state;
    w_done  = 1'b0;
    w_cyc   = r_cyc;
    w_we    = r_we;
    w_sel   = r_sel;
    w_adr   = r_adr;
    w_dat   = r_dat;
    w_rdata = r_rdata;
    case (r_state)
      IDLE: if (d_write_en || d_read_en) begin
        w_state = BUS;
        w_cyc   = 1'b1;
        w_we    = d_write_en;
        w_sel   = 4'hF;
        w_adr   = d_addr;
        w_dat   = d_write_data;
      end
      BUS: if (wbm_ack_i || w_to) begin
        w_state = DONE;
        w_done  = 1'b1;
        w_cyc   = 1'b0;
        w_we    = 1'b0;
        w_sel   = 4'h0;
        w_rdata = r_we ? r_rdata : (wbm_ack_i ? wbm_dat_i : 32'hFFFF_FFFF);
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  assign done_o     = r_done;
  assign d_data_out = r_rdata;
  assign wbm_dat_o  = r_dat;
  assign wbm_we_o   = r_we;
  assign wbm_sel_o  = r_sel;
  assign wbm_adr_o  = r_adr;
  assign wbm_cyc_o  = r_cyc;
  assign wbm_stb_o  = r_cyc;
endmodule

// File: tb/tb_master_wb_bridge.sv
// tb_master_wb_bridge: drives CPU requests and a behavioural Wishbone slave, checking against a
// transaction-level model (latched fields, cycle length = waits+1, one done pulse, last read value).
module tb_master_wb_bridge;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        d_read_en = 1'b0, d_write_en = 1'b0, wbm_ack_i = 1'b0;
  logic [31:0] d_addr = '0, d_write_data = '0, wbm_dat_i = '0;
  logic        done_o, wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] d_data_out, wbm_dat_o, wbm_adr_o;
  int          n_checks = 0, n_errors = 0;
  logic [31:0] m_rdata = '0;
  int          obs_cyc, obs_done, obs_hung;
  logic        obs_stable, obs_we, obs_done_end, obs_cyc_after;
  logic [3:0]  obs_sel;
  logic [31:0] obs_adr, obs_dat;

  always #5 clk = ~clk;

  master_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .done_o(done_o),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_write_data(d_write_data), .d_data_out(d_data_out),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, plays a slave that acks after `waits` wait states, records what it saw.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int waits);
    int n = 0;
    d_read_en = rd; d_write_en = wr; d_addr = a; d_write_data = wd;
    obs_cyc = 0; obs_done = 0; obs_hung = 0; obs_stable = 1'b1;
    step();
    obs_adr = wbm_adr_o; obs_dat = wbm_dat_o; obs_we = wbm_we_o; obs_sel = wbm_sel_o;
    while (wbm_cyc_o) begin
      obs_cyc++;
      obs_done += int'(done_o);
      if (wbm_stb_o !== 1'b1 || wbm_adr_o !== obs_adr || wbm_dat_o !== obs_dat ||
          wbm_we_o !== obs_we || wbm_sel_o !== obs_sel) obs_stable = 1'b0;
      wbm_ack_i = (n == waits);
      wbm_dat_i = (n == waits) ? rdat : $urandom();
      n++;
      d_addr = $urandom(); d_write_data = $urandom();
      step();
      wbm_ack_i = 1'b0;
      if (n > 300) begin
        obs_hung = 1;
        break;
      end
    end
    obs_done_end = done_o;
    obs_done += int'(done_o);
    d_read_en = 1'b0; d_write_en = 1'b0;
    obs_cyc_after = 1'b0;
    repeat (3) begin
      wbm_ack_i = 1'($urandom_range(0, 1));
      wbm_dat_i = $urandom();
      step();
      obs_done += int'(done_o);
      obs_cyc_after |= wbm_cyc_o;
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic seen = 1'b0;
    rst = 1'b0;
    step();
    n_checks++;
    if ({done_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, d_data_out} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: adr=%h dat=%h rd=%h cyc=%b done=%b, required all zero",
                           wbm_adr_o, wbm_dat_o, d_data_out, wbm_cyc_o, done_o);
    end
    rst = 1'b1;
    step();
    d_read_en = 1'b1; d_addr = 32'h55AA_0000 | 32'($urandom_range(1, 255)); d_write_data = 32'h0BAD_BEEF;
    step();
    n_checks++;
    if (wbm_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_bus_start: cyc=%b required 1", wbm_cyc_o);
    end
    step();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({done_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, d_data_out} !== '0) begin
      n_errors++; $display("FAIL reset_async_mid_bus: adr=%h dat=%h cyc=%b stb=%b sel=%h, required all zero",
                           wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_sel_o);
    end
    d_read_en = 1'b0;
    step();
    rst = 1'b1;
    repeat (4) begin
      wbm_ack_i = 1'b1;
      step();
      seen |= done_o | wbm_cyc_o;
    end
    wbm_ack_i = 1'b0;
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++; $display("FAIL reset_request_lost: done/cyc seen=%b required 0", seen);
    end
    m_rdata = '0;
  endtask

  task automatic test_zero_wait_read();
    run_txn(1'b1, 1'b0, 32'h0000_1004, 32'h1111_2222, 32'hCAFE_F00D, 0);
    m_rdata = 32'hCAFE_F00D;
    n_checks++;
    if (obs_adr !== 32'h0000_1004 || obs_sel !== 4'hF || obs_we !== 1'b0) begin
      n_errors++; $display("FAIL zw_read_fields: adr=%h sel=%h we=%b required 00001004 f 0", obs_adr, obs_sel, obs_we);
    end
    n_checks++;
    if (obs_cyc !== 1 || obs_done_end !== 1'b1) begin
      n_errors++; $display("FAIL zw_read_timing: cyc_cycles=%0d done_after=%b required 1 1", obs_cyc, obs_done_end);
    end
    n_checks++;
    if (obs_done !== 1) begin
      n_errors++; $display("FAIL zw_read_done_count: got %0d required 1", obs_done);
    end
    n_checks++;
    if (d_data_out !== m_rdata) begin
      n_errors++; $display("FAIL zw_read_data: got %h required %h", d_data_out, m_rdata);
    end
  endtask

  task automatic test_write_wait();
    run_txn(1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hDEAD_0000, 3);
    n_checks++;
    if (obs_cyc !== 4 || obs_stable !== 1'b1 || obs_hung !== 0) begin
      n_errors++; $display("FAIL wr3_cycle: cyc_cycles=%0d stable=%b required 4 1", obs_cyc, obs_stable);
    end
    n_checks++;
    if (obs_we !== 1'b1 || obs_dat !== 32'h1234_5678 || obs_adr !== 32'h0000_2000) begin
      n_errors++; $display("FAIL wr3_fields: we=%b dat=%h adr=%h required 1 12345678 00002000", obs_we, obs_dat, obs_adr);
    end
    n_checks++;
    if (obs_done !== 1 || obs_cyc_after !== 1'b0) begin
      n_errors++; $display("FAIL wr3_done: pulses=%0d cyc_after=%b required 1 0", obs_done, obs_cyc_after);
    end
    n_checks++;
    if (d_data_out !== m_rdata) begin
      n_errors++; $display("FAIL wr3_rdata_kept: got %h required %h", d_data_out, m_rdata);
    end
  endtask

  task automatic test_both();
    logic [31:0] wd = $urandom();
    run_txn(1'b1, 1'b1, 32'h0000_0ABC, wd, 32'h7777_7777, int'($urandom_range(0, 3)));
    n_checks++;
    if (obs_we !== 1'b1 || obs_dat !== wd) begin
      n_errors++; $display("FAIL both_write_wins: we=%b dat=%h required 1 %h", obs_we, obs_dat, wd);
    end
    n_checks++;
    if (obs_done !== 1 || d_data_out !== m_rdata) begin
      n_errors++; $display("FAIL both_done: pulses=%0d rdata=%h required 1 %h", obs_done, d_data_out, m_rdata);
    end
  endtask

  task automatic test_held();
    int dones = 0;
    d_read_en = 1'b1; d_write_en = 1'b0; d_addr = 32'h3000_0040;
    step();
    n_checks++;
    if (wbm_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL held_start: cyc=%b required 1", wbm_cyc_o);
    end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0001;
    step();
    wbm_ack_i = 1'b0;
    dones += int'(done_o);
    step();
    n_checks++;
    if (wbm_cyc_o !== 1'b0 || done_o !== 1'b0) begin
      n_errors++; $display("FAIL held_idle_gap: cyc=%b done=%b required 0 0", wbm_cyc_o, done_o);
    end
    step();
    n_checks++;
    if (wbm_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL held_restart: cyc=%b required 1", wbm_cyc_o);
    end
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_0002;
    step();
    wbm_ack_i = 1'b0;
    dones += int'(done_o);
    d_read_en = 1'b0;
    repeat (2) begin
      step();
      dones += int'(done_o);
    end
    m_rdata = 32'hA5A5_0002;
    n_checks++;
    if (dones !== 2 || d_data_out !== m_rdata) begin
      n_errors++; $display("FAIL held_two_txns: pulses=%0d rdata=%h required 2 %h", dones, d_data_out, m_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic        wr = 1'($urandom_range(0, 1));
      logic        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      logic [31:0] a = $urandom(), wd = $urandom(), rdat = $urandom();
      int          w = int'($urandom_range(0, 3));
      run_txn(rd, wr, a, wd, rdat, w);
      if (!wr) m_rdata = rdat;
      n_checks++;
      if (obs_adr !== a || obs_dat !== wd || obs_we !== wr || obs_sel !== 4'hF) begin
        n_errors++; $display("FAIL rnd%0d_fields: adr=%h dat=%h we=%b sel=%h required %h %h %b f",
                             i, obs_adr, obs_dat, obs_we, obs_sel, a, wd, wr);
      end
      n_checks++;
      if (obs_cyc !== w + 1 || obs_stable !== 1'b1 || obs_done !== 1 || obs_cyc_after !== 1'b0) begin
        n_errors++; $display("FAIL rnd%0d_timing: cyc_cycles=%0d stable=%b pulses=%0d cyc_after=%b required %0d 1 1 0",
                             i, obs_cyc, obs_stable, obs_done, obs_cyc_after, w + 1);
      end
      n_checks++;
      if (d_data_out !== m_rdata) begin
        n_errors++; $display("FAIL rnd%0d_rdata: got %h required %h", i, d_data_out, m_rdata);
      end
    end
  endtask

`ifdef MASTER_WB_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_0000, 1000);
    m_rdata = 32'hFFFF_FFFF;
    n_checks++;
    if (obs_cyc !== TO || obs_done !== 1) begin
      n_errors++; $display("FAIL timeout_len: cyc_cycles=%0d pulses=%0d required %0d 1", obs_cyc, obs_done, TO);
    end
    n_checks++;
    if (d_data_out !== m_rdata) begin
      n_errors++; $display("FAIL timeout_rdata: got %h required %h", d_data_out, m_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_both();
    test_held();
    test_random();
`ifdef MASTER_WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/master_wb_bridge.md
# master_wb_bridge

Single-master Wishbone (B3 classic) bus interface for the CPU data port of `master_wb`. It converts level-held CPU load/store requests (`d_read_en` / `d_write_en`) into one Wishbone single-read or single-write cycle. It returns read data and signals completion with a one-cycle `done_o` pulse. It sits between the MIPS core's memory stage and the system Wishbone interconnect; instruction fetch does not pass through it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles without `wbm_ack_i` before the bridge aborts a cycle. Used only when `MASTER_WB_TIMEOUT_EN` is defined. Range 1..65535.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low (`rst`=0 resets).
- `done_o`  out  1  one-cycle completion pulse for the current request.
- `d_read_en`  in  1  CPU load request, held until `done_o`.
- `d_write_en`  in  1  CPU store request, held until `done_o`.
- `d_addr`  in  32  byte address of the request.
- `d_write_data`  in  32  store data.
- `d_data_out`  out  32  registered load data.
- `wbm_dat_i`  in  32  Wishbone read data.
- `wbm_ack_i`  in  1  Wishbone acknowledge.
- `wbm_dat_o`  out  32  Wishbone write data.
- `wbm_we_o`  out  1  Wishbone write enable.
- `wbm_sel_o`  out  4  byte selects.
- `wbm_adr_o`  out  32  Wishbone address.
- `wbm_cyc_o`  out  1  Wishbone cycle.
- `wbm_stb_o`  out  1  Wishbone strobe.

## Operation
- FSM states: IDLE, BUS, DONE. All outputs are registered.
- **IDLE**
  - `cyc`, `stb`, `we`, `done_o` are 0; `sel` is 4'b0000.
  - On a clock edge with `d_write_en`=1 or `d_read_en`=1, go to BUS.
  - Latch `d_addr` into `wbm_adr_o` unmodified (byte address, no shift).
  - Latch `d_write_data` into `wbm_dat_o`.
  - Set `we`=`d_write_en`, `sel`=4'b1111, `cyc`=`stb`=1.
  - If both request inputs are high, the write wins.
- **BUS**
  - Hold address, data, `we`, `sel`, `cyc` and `stb` constant.
  - On an edge with `wbm_ack_i`=1:
    - Drop `cyc`/`stb`/`we`; set `sel`=0.
    - For a read, capture `wbm_dat_i` into `d_data_out`.
    - Set `done_o`=1 and go to DONE.
  - `wbm_ack_i` is ignored in IDLE and DONE.
- **DONE**
  - `done_o` stays high for exactly this one cycle.
  - Next edge: `done_o`=0, go to IDLE. No new request is sampled in DONE.
- `d_data_out` holds the last completed read value. Writes never change it.
- `wbm_adr_o` and `wbm_dat_o` keep their last values outside a cycle.

## Timing
- Reset (async assert, sync release): state IDLE; every output is 0, including `d_data_out`, `wbm_adr_o` and `wbm_dat_o`.
- Reset during BUS: `cyc`/`stb` drop immediately; no `done_o`; the request is lost.
- Request high before edge E0: `cyc`/`stb` are high from E0.
- Ack sampled at edge Ek: `cyc`/`stb` low and `done_o` high from Ek to Ek+1.
- Minimum turnaround: zero-wait slave (ack in the first cycle) gives `done_o` one cycle after `cyc` rises.
- Next request can be accepted at Ek+2 at the earliest.
- Back-to-back: if a request input is still high in IDLE after DONE, a new cycle starts. The CPU must deassert after seeing `done_o`.
- Wait states: unbounded; the bridge stays in BUS until ack (unless timeout is enabled).

## Configuration
- `MASTER_WB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering BUS and increments each BUS cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the bridge terminates the cycle as if acked: `cyc`/`stb` drop and `done_o` pulses.
  - For a read, `d_data_out`=32'hFFFF_FFFF.
  - An ack on the same edge takes precedence over the timeout.
- `MASTER_WB_TIMEOUT_EN` undefined: no counter; BUS waits forever; `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset: drive `rst`=0 mid-BUS → all outputs 0 asynchronously; no `done_o`; state IDLE.
- Zero-wait read: read `d_addr`=32'h0000_1004, slave acks the first cycle with 32'hCAFE_F00D.
  - `wbm_adr_o`=32'h0000_1004, `wbm_sel_o`=4'hF, `wbm_we_o`=0.
  - `done_o` one cycle later; `d_data_out`=32'hCAFE_F00D.
- 3-wait write: write 32'h1234_5678 to 32'h2000.
  - `cyc`/`stb`/`we` high for 4 cycles; `wbm_dat_o` stable throughout.
  - Single `done_o` pulse; `d_data_out` unchanged.
- Simultaneous read and write enables → write cycle issued (`we`=1); `done_o` pulses exactly once.
- Held request: request held 1 extra cycle after `done_o` → second cycle starts only after the DONE cycle; IDLE is visible for at least 1 cycle.
- With `MASTER_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never acks a read → `done_o` after 4 BUS cycles; `d_data_out`=32'hFFFF_FFFF.
